// File: rtl/fp16_square_iter_if.sv
// rtl/fp16_square_iter_if.sv - operand/result valid-ready handshake bundle for fp16_square_iter
interface fp16_square_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fp16_square_iter.sv
// rtl/fp16_square_iter.sv - iterative FP16 squarer (y = x*x), shift-add mantissa multiply
// Optional round-to-nearest-even packing is enabled by defining FP16_SQUARE_RNE_EN.
module fp16_square_iter #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    fp16_square_iter_if.slave sq_if
);
    localparam int N_MUL = 11 / BITS_PER_CYCLE;

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_MUL, S_PACK, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       opnd_q, opnd_d;
    logic [21:0]       mcand_q, mcand_d;
    logic [21:0]       acc_q, acc_d;
    logic [10:0]       mplier_q, mplier_d;
    logic [3:0]        cnt_q, cnt_d;
    logic signed [6:0] e_q, e_d;
    logic              zero_q, zero_d;
    logic              inf_q, inf_d;
    logic              nan_q, nan_d;
    logic [15:0]       out_data_q, out_data_d;

    logic [4:0]        exp_u;
    logic [9:0]        frac_u;
    logic [3:0]        clz_u;
    logic [10:0]       m_u;
    logic signed [6:0] e_u;
    logic              unused_sign;

    assign unused_sign = opnd_q[15];

    // Subnormals are normalised so the mantissa always carries its leading one at bit 10.
    always_comb begin
        exp_u  = opnd_q[14:10];
        frac_u = opnd_q[9:0];
        clz_u  = 4'd10;
        for (int i = 0; i < 10; i++) begin
            if (frac_u[i]) clz_u = 4'(9 - i);
        end
        if (exp_u == 5'd0) begin
            m_u = {1'b0, frac_u} << (clz_u + 4'd1);
            e_u = -7'sd15 - $signed({3'b000, clz_u});
        end else begin
            m_u = {1'b1, frac_u};
            e_u = $signed({2'b00, exp_u}) - 7'sd15;
        end
    end

    logic [21:0] mul_sum;

    always_comb begin
        mul_sum = acc_q;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (mplier_q[k]) mul_sum = mul_sum + (mcand_q << k);
        end
    end

    logic              hi_p;
    logic [10:0]       mant_p;
    logic [10:0]       mant_sh;
    logic signed [7:0] b_p;
    logic              b_le0;
    logic [7:0]        sh_p;
    logic [14:0]       base_p;
    logic              round_up;
    logic [15:0]       pack_res;

    // e2 = 2e + hi is just e with hi appended as the new LSB.
    always_comb begin
        hi_p    = acc_q[21];
        mant_p  = hi_p ? acc_q[21:11] : acc_q[20:10];
        b_p     = $signed({e_q, hi_p}) + 8'sd15;
        b_le0   = (b_p <= 8'sd0);
        sh_p    = b_le0 ? 8'(8'sd1 - b_p) : 8'd0;
        mant_sh = mant_p >> sh_p;
        base_p  = b_le0 ? {4'b0000, mant_sh} : {b_p[4:0], mant_p[9:0]};
    end

`ifdef FP16_SQUARE_RNE_EN
    logic [21:0] wide_p;
    logic [21:0] shifted_p;
    logic [21:0] mask_p;
    logic        guard_p;
    logic        sticky_p;
    logic        unused_rnd;

    // Guard is the first dropped bit; sticky covers the rest of the product and the subnormal shift-out.
    always_comb begin
        wide_p    = {mant_p, hi_p ? acc_q[10:0] : {acc_q[9:0], 1'b0}};
        shifted_p = wide_p >> sh_p;
        mask_p    = (22'd1 << sh_p) - 22'd1;
        guard_p   = shifted_p[10];
        sticky_p  = (|shifted_p[9:0]) | (|(wide_p & mask_p));
        round_up  = guard_p & (sticky_p | base_p[0]);
    end

    assign unused_rnd = ^shifted_p[21:11];
`else
    logic unused_low;

    assign round_up   = 1'b0;
    assign unused_low = ^acc_q[9:0];
`endif

    // A rounding carry ripples from the fraction into the exponent field, reaching 7C00 at the top.
    always_comb begin
        if (nan_q)                  pack_res = 16'h7E00;
        else if (inf_q)             pack_res = 16'h7C00;
        else if (zero_q)            pack_res = 16'h0000;
        else if (b_p >= 8'sd31)     pack_res = 16'h7C00;
        else                        pack_res = {1'b0, base_p + {14'd0, round_up}};
    end

    always_comb begin
        state_d    = state_q;
        opnd_d     = opnd_q;
        mcand_d    = mcand_q;
        acc_d      = acc_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        e_d        = e_q;
        zero_d     = zero_q;
        inf_d      = inf_q;
        nan_d      = nan_q;
        out_data_d = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (sq_if.in_valid) begin
                    opnd_d  = sq_if.in_data;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                mcand_d  = {11'd0, m_u};
                mplier_d = m_u;
                acc_d    = '0;
                cnt_d    = '0;
                e_d      = e_u;
                zero_d   = (exp_u == 5'd0)  && (frac_u == 10'd0);
                inf_d    = (exp_u == 5'd31) && (frac_u == 10'd0);
                nan_d    = (exp_u == 5'd31) && (frac_u != 10'd0);
                state_d  = S_MUL;
            end
            S_MUL: begin
                acc_d    = mul_sum;
                mcand_d  = mcand_q << BITS_PER_CYCLE;
                mplier_d = mplier_q >> BITS_PER_CYCLE;
                cnt_d    = cnt_q + 4'd1;
                if (cnt_q == 4'(N_MUL - 1)) state_d = S_PACK;
            end
            S_PACK: begin
                out_data_d = pack_res;
                state_d    = S_DONE;
            end
            S_DONE: begin
                if (sq_if.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            opnd_q     <= '0;
            mcand_q    <= '0;
            acc_q      <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
            e_q        <= '0;
            zero_q     <= 1'b0;
            inf_q      <= 1'b0;
            nan_q      <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            opnd_q     <= opnd_d;
            mcand_q    <= mcand_d;
            acc_q      <= acc_d;
            mplier_q   <= mplier_d;
            cnt_q      <= cnt_d;
            e_q        <= e_d;
            zero_q     <= zero_d;
            inf_q      <= inf_d;
            nan_q      <= nan_d;
            out_data_q <= out_data_d;
        end
    end

    assign sq_if.in_ready  = (state_q == S_IDLE);
    assign sq_if.out_valid = (state_q == S_DONE);
    assign sq_if.out_data  = out_data_q;
endmodule

// File: tb/tb_fp16_square_iter.sv
// tb/tb_fp16_square_iter.sv - self-checking bench for fp16_square_iter (1 and 11 bits per cycle)
module tb_fp16_square_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    fp16_square_iter_if if0 ();
    fp16_square_iter_if if1 ();

    fp16_square_iter #(.BITS_PER_CYCLE(1))  u_dut0 (.clk(clk), .rst(rst), .sq_if(if0));
    fp16_square_iter #(.BITS_PER_CYCLE(11)) u_dut1 (.clk(clk), .rst(rst), .sq_if(if1));

    // Exact square as integer significand times a power of two, then re-encoded to FP16.
    function automatic logic [15:0] ref_sq(input logic [15:0] x);
        int     ex, e, k, u, s;
        longint m, p, q, rem, half;
        ex = int'(x[14:10]);
        if (ex == 31) return (x[9:0] != 10'd0) ? 16'h7E00 : 16'h7C00;
        if (ex == 0) begin m = longint'(x[9:0]);        e = -24;     end
        else         begin m = 1024 + longint'(x[9:0]); e = ex - 25; end
        if (m == 0) return 16'h0000;
        p = m * m;
        k = 0;
        for (int i = 0; i < 24; i++) if (p[i]) k = i;
        u = k + 2 * e;
        s = (u >= -14) ? k - 10 : -(2 * e + 24);
        if (s > 0) begin
            q = p >> s;
            rem = p & ((longint'(1) << s) - 1);
            half = longint'(1) << (s - 1);
        end else begin
            q = p << (-s);
            rem = 0;
            half = 1;
        end
`ifdef FP16_SQUARE_RNE_EN
        if (rem > half || (rem == half && q[0])) q = q + 1;
`else
        if (rem < 0 || half < 0) q = 0;
`endif
        if (u >= -14) begin
            if (q == 2048) begin q = 1024; u = u + 1; end
            if (u >= 16) return 16'h7C00;
            return {1'b0, 5'(u + 15), q[9:0]};
        end
        return q[15:0];
    endfunction

    task automatic start_op(input bit sel, input logic [15:0] x, output bit to);
        int n = 0;
        to = 1'b0;
        while (!(sel ? if1.in_ready : if0.in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin to = 1'b1; return; end
        if (sel) begin if1.in_valid = 1'b1; if1.in_data = x; end
        else     begin if0.in_valid = 1'b1; if0.in_data = x; end
        @(negedge clk);
        if (sel) if1.in_valid = 1'b0; else if0.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input bit sel, output int lat, output bit to);
        lat = 0;
        to = 1'b0;
        while (!(sel ? if1.out_valid : if0.out_valid) && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 100) begin to = 1'b1; lat = -1; end
    endtask

    task automatic do_op(input bit sel, input logic [15:0] x, output logic [15:0] y, output int lat);
        bit to;
        start_op(sel, x, to);
        if (to) begin y = 'x; lat = -1; return; end
        wait_valid(sel, lat, to);
        if (to) begin y = 'x; return; end
        y = sel ? if1.out_data : if0.out_data;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if (if0.in_ready !== 1'b1)      $display("FAIL reset in_ready: got %b expected 1", if0.in_ready);   else n_pass++;
        n_total++; if (if0.out_valid !== 1'b0)     $display("FAIL reset out_valid: got %b expected 0", if0.out_valid); else n_pass++;
        n_total++; if (if0.out_data !== 16'h0000)  $display("FAIL reset out_data: got %h expected 0000", if0.out_data); else n_pass++;
        n_total++; if (if1.in_ready !== 1'b1)      $display("FAIL reset dut1 in_ready: got %b expected 1", if1.in_ready); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [15:0] din [11];
        logic [15:0] dexp [11];
        logic [15:0] y;
        int          lat;
        din  = '{16'h3C00, 16'h3E00, 16'hC200, 16'h4000, 16'h5C00, 16'h7E01,
                 16'hFC00, 16'h8000, 16'h0C00, 16'h0800, 16'h0001};
        dexp = '{16'h3C00, 16'h4080, 16'h4880, 16'h4400, 16'h7C00, 16'h7E00,
                 16'h7C00, 16'h0000, 16'h0001, 16'h0000, 16'h0000};
        for (int i = 0; i < 11; i++) begin
            do_op(1'b0, din[i], y, lat);
            n_total++; if (y !== dexp[i]) $display("FAIL directed[%0d] data: got %h expected %h", i, y, dexp[i]); else n_pass++;
            n_total++; if (lat !== 13)    $display("FAIL directed[%0d] latency: got %0d expected 13", i, lat); else n_pass++;
        end
    endtask

    task automatic test_rounding();
        logic [15:0] y;
        logic [15:0] exp_y;
        int          lat;
`ifdef FP16_SQUARE_RNE_EN
        exp_y = 16'h3C2F;
`else
        exp_y = 16'h3C2E;
`endif
        do_op(1'b0, 16'h3C17, y, lat);
        n_total++; if (y !== exp_y) $display("FAIL rounding 3C17: got %h expected %h", y, exp_y); else n_pass++;
    endtask

    task automatic test_random();
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] exp_y;
        int          lat;
        for (int i = 0; i < 300; i++) begin
            x = 16'($urandom);
            if (i % 3 == 0) x[14:10] = 5'($urandom_range(0, 8));
            if (i % 3 == 1) x[14:10] = 5'($urandom_range(20, 24));
            exp_y = ref_sq(x);
            do_op(1'b0, x, y, lat);
            n_total++; if (y !== exp_y) $display("FAIL random x=%h: got %h expected %h", x, y, exp_y); else n_pass++;
            n_total++; if (lat !== 13)  $display("FAIL random latency x=%h: got %0d expected 13", x, lat); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        bit to;
        int lat;
        if0.out_ready = 1'b0;
        start_op(1'b0, 16'h3E00, to);
        if (!to) wait_valid(1'b0, lat, to);
        else lat = -1;
        n_total++; if (lat !== 13) $display("FAIL backpressure latency: got %0d expected 13", lat); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_total++; if (if0.out_valid !== 1'b1)    $display("FAIL hold[%0d] out_valid: got %b expected 1", i, if0.out_valid); else n_pass++;
            n_total++; if (if0.out_data !== 16'h4080) $display("FAIL hold[%0d] out_data: got %h expected 4080", i, if0.out_data); else n_pass++;
            n_total++; if (if0.in_ready !== 1'b0)     $display("FAIL hold[%0d] in_ready: got %b expected 0", i, if0.in_ready); else n_pass++;
            @(negedge clk);
        end
        if0.out_ready = 1'b1;
        @(negedge clk);
        n_total++; if (if0.out_valid !== 1'b0)    $display("FAIL release out_valid: got %b expected 0", if0.out_valid); else n_pass++;
        n_total++; if (if0.in_ready !== 1'b1)     $display("FAIL release in_ready: got %b expected 1", if0.in_ready); else n_pass++;
        n_total++; if (if0.out_data !== 16'h4080) $display("FAIL release out_data held: got %h expected 4080", if0.out_data); else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        bit          to;
        logic [15:0] y;
        int          lat;
        start_op(1'b0, 16'h4000, to);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_total++; if (if0.in_ready !== 1'b1)     $display("FAIL midreset in_ready: got %b expected 1", if0.in_ready); else n_pass++;
        n_total++; if (if0.out_valid !== 1'b0)    $display("FAIL midreset out_valid: got %b expected 0", if0.out_valid); else n_pass++;
        n_total++; if (if0.out_data !== 16'h0000) $display("FAIL midreset out_data: got %h expected 0000", if0.out_data); else n_pass++;
        rst = 1'b0;
        do_op(1'b0, 16'h4000, y, lat);
        n_total++; if (y !== 16'h4400) $display("FAIL after midreset data: got %h expected 4400", y); else n_pass++;
        n_total++; if (lat !== 13)     $display("FAIL after midreset latency: got %0d expected 13", lat); else n_pass++;
    endtask

    task automatic test_bpc11();
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] exp_y;
        int          lat;
        do_op(1'b1, 16'h3C00, y, lat);
        n_total++; if (y !== 16'h3C00) $display("FAIL bpc11 1.0 data: got %h expected 3C00", y); else n_pass++;
        n_total++; if (lat !== 3)      $display("FAIL bpc11 1.0 latency: got %0d expected 3", lat); else n_pass++;
        do_op(1'b1, 16'h3E00, y, lat);
        n_total++; if (y !== 16'h4080) $display("FAIL bpc11 1.5 data: got %h expected 4080", y); else n_pass++;
        n_total++; if (lat !== 3)      $display("FAIL bpc11 1.5 latency: got %0d expected 3", lat); else n_pass++;
        for (int i = 0; i < 60; i++) begin
            x = 16'($urandom);
            exp_y = ref_sq(x);
            do_op(1'b1, x, y, lat);
            n_total++; if (y !== exp_y) $display("FAIL bpc11 random x=%h: got %h expected %h", x, y, exp_y); else n_pass++;
            n_total++; if (lat !== 3)   $display("FAIL bpc11 random latency x=%h: got %0d expected 3", x, lat); else n_pass++;
        end
    endtask

    initial begin
        if0.in_valid = 1'b0; if0.in_data = 16'h0000; if0.out_ready = 1'b1;
        if1.in_valid = 1'b0; if1.in_data = 16'h0000; if1.out_ready = 1'b1;
        test_reset();
        test_directed();
        test_rounding();
        test_random();
        test_backpressure();
        test_reset_mid_op();
        test_bpc11();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
